// File: rtl/ex_mem_reg_pkg.sv
// Shared core types for the EX/MEM boundary: MEM- and WB-stage control bundles
// and their all-zero bubble values.
package ex_mem_reg_pkg;

  typedef struct packed {
    logic       Branch;
    logic       Jump;
    logic       MemRead;
    logic       MemWrite;
    logic [2:0] MemSize;
  } mem_ctrl_t;

  typedef struct packed {
    logic       RegWrite;
    logic [1:0] ResultSrc;
  } wb_ctrl_t;

  localparam mem_ctrl_t MEM_CTRL_BUBBLE = '0;
  localparam wb_ctrl_t  WB_CTRL_BUBBLE  = '0;

endpackage

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: flush beats stall beats load. Bubbles never carry
// live control, so nothing downstream can fire from an invalid slot.
module ex_mem_reg
  import ex_mem_reg_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_valid,
  input  logic            i_stall,
  input  logic            i_flush,
  input  logic [XLEN-1:0] i_aluResult,
  input  logic [XLEN-1:0] i_wrData,
  input  logic [XLEN-1:0] i_branchTarget,
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_zero,
  input  logic [4:0]      i_rd,
  input  mem_ctrl_t       i_ctrlMEM,
  input  wb_ctrl_t        i_ctrlWB,
  output logic            o_valid,
  output logic [XLEN-1:0] o_memAddr,
  output logic [XLEN-1:0] o_wrData,
  output logic [XLEN-1:0] o_branchTarget,
  output logic [XLEN-1:0] o_pc,
  output logic            o_zero,
  output logic [4:0]      o_rd,
  output mem_ctrl_t       o_ctrlMEM,
  output wb_ctrl_t        o_ctrlWB,
  output logic            o_fwdRegWrite
);

  logic load;
  assign load = !i_flush && !i_stall;

  // Valid/control group: the only state whose value matters in a bubble.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_valid   <= 1'b0;
      o_ctrlMEM <= MEM_CTRL_BUBBLE;
      o_ctrlWB  <= WB_CTRL_BUBBLE;
    end else if (i_flush) begin
      o_valid   <= 1'b0;
      o_ctrlMEM <= MEM_CTRL_BUBBLE;
      o_ctrlWB  <= WB_CTRL_BUBBLE;
    end else if (!i_stall) begin
      o_valid   <= i_valid;
      o_ctrlMEM <= i_valid ? i_ctrlMEM : MEM_CTRL_BUBBLE;
      o_ctrlWB  <= i_valid ? i_ctrlWB  : WB_CTRL_BUBBLE;
    end
  end

  // Datapath group: contents are don't-care after a flush, so it simply holds.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_memAddr      <= '0;
      o_wrData       <= '0;
      o_branchTarget <= '0;
      o_pc           <= '0;
      o_zero         <= 1'b0;
      o_rd           <= 5'd0;
    end else if (load) begin
      o_memAddr      <= i_aluResult;
      o_wrData       <= i_wrData;
      o_branchTarget <= i_branchTarget;
      o_pc           <= i_pc;
      o_zero         <= i_zero;
      o_rd           <= i_rd;
    end
  end

  assign o_fwdRegWrite = o_valid & o_ctrlWB.RegWrite & (o_rd != 5'd0);

endmodule

// File: doc/ex_mem_reg.md
EX_MEM_REG -- requirements
Module: ex_mem_reg

Interface
REQ-001 SHALL have parameter XLEN, default 32, giving the datapath width.
REQ-002 SHALL have port i_clk, input, 1, the single rising-edge clock.
REQ-003 SHALL have port i_reset_n, input, 1, the reset: asynchronous, active-low.
REQ-004 SHALL have port i_valid, input, 1, EX stage holds a real instruction.
REQ-005 SHALL have port i_stall, input, 1, hold current contents.
REQ-006 SHALL have port i_flush, input, 1, replace next contents with a bubble.
REQ-007 SHALL have port i_aluResult, input, XLEN, ALU result / memory address.
REQ-008 SHALL have port i_wrData, input, XLEN, store data (rs2 after forwarding).
REQ-009 SHALL have port i_branchTarget, input, XLEN, computed branch/jump target.
REQ-010 SHALL have port i_pc, input, XLEN, PC of the EX instruction.
REQ-011 SHALL have port i_zero, input, 1, ALU zero flag.
REQ-012 SHALL have port i_rd, input, 5, destination register index.
REQ-013 SHALL have port i_ctrlMEM, input, mem_ctrl_t, MEM-stage control.
REQ-014 SHALL have port i_ctrlWB, input, wb_ctrl_t, WB-stage control.
REQ-015 SHALL have outputs o_valid (1), o_memAddr, o_wrData, o_branchTarget and o_pc (XLEN each), o_zero (1), o_rd (5), o_ctrlMEM (mem_ctrl_t) and o_ctrlWB (wb_ctrl_t); each is the registered copy of its matching input.
REQ-016 SHALL have port o_fwdRegWrite, output, 1, combinational: o_valid & o_ctrlWB.RegWrite & (o_rd != 0).

Function
REQ-017 SHALL, on each rising edge, follow this priority: flush, then stall, then load.
REQ-018 SHALL, on flush, set o_valid=0 and set o_ctrlMEM and o_ctrlWB to all zeros; flush SHALL override a simultaneous stall.
REQ-019 SHALL, on stall without flush, hold every output register unchanged.
REQ-020 SHALL, on load, capture all inputs with one-cycle latency and set o_valid=i_valid.
REQ-021 SHALL, on load with i_valid=0, force the captured control structs to zero, so no bubble can assert Branch, Jump, MemRead, MemWrite or RegWrite.
REQ-022 SHALL capture datapath fields (addr, data, target, pc, rd, zero) on a flush or bubble only as don't-care values; holding the old value is allowed.
REQ-023 SHALL keep o_ctrlMEM.Branch|Jump at 0 whenever o_valid=0, so a downstream o_PCSrc never fires from a bubble.
REQ-024 SHALL pass widths through with no truncation or extension.

Reset
REQ-025 SHALL, while i_reset_n=0, drive every output register to zero (o_valid=0, both control structs zero), independent of the clock.
REQ-026 SHALL, after reset is released, load on the next edge without needing a flush.
REQ-027 SHALL, if reset is asserted mid-stall, clear immediately; the stall SHALL have no effect until reset is released.

Structure
REQ-028 SHALL take mem_ctrl_t and wb_ctrl_t from the shared core package; the package SHALL also define a BUBBLE constant for each struct (all zeros).
REQ-029 SHALL be a single module with no sub-modules; there SHALL be a valid/control register group and a datapath register group.

Verification
REQ-030 Load: i_valid=1, aluResult=0x0000_1004, rd=5, RegWrite=1 -> next edge o_memAddr=0x1004, o_rd=5, o_valid=1, o_fwdRegWrite=1.
REQ-031 Stall: load 0xA, then i_stall=1 with aluResult=0xB for 3 cycles -> o_memAddr stays 0xA; release -> 0xB on the next edge.
REQ-032 Flush+stall together with Jump=1 on input -> next edge o_valid=0, o_ctrlMEM.Jump=0, o_ctrlWB.RegWrite=0.
REQ-033 Bubble: i_valid=0 with MemWrite=1, Branch=1 -> o_ctrlMEM.MemWrite=0, Branch=0.
REQ-034 Forward gate: RegWrite=1, rd=0, valid=1 -> o_fwdRegWrite=0.
REQ-035 Async reset pulse between edges while loaded -> all outputs 0 immediately, before the next clock edge.
